// File: rtl/mcpu_soc_mmio_router_pkg.sv
// Shared definitions for the MMIO router and its address decoder:
// FSM encodings, error kinds, default region size and well-known slot indices.
package mcpu_soc_mmio_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic ERR_UNMAPPED = 1'b0;
  localparam logic ERR_TIMEOUT  = 1'b1;

  localparam int DEF_REGION_BITS = 12;

  localparam int SLOT_LEDSW = 0;
  localparam int SLOT_UART  = 1;
  localparam int SLOT_I2C   = 2;
  localparam int SLOT_SD    = 3;
  localparam int SLOT_AUDIO = 4;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcpu_soc_mmio_decode.sv
// Combinational word-address decoder: region index -> hit, one-hot select,
// binary index and in-region word offset. Also used by the debug bridge.
module mcpu_soc_mmio_decode
  import mcpu_soc_mmio_router_pkg::*;
#(
  parameter int N_SLOTS     = 8,
  parameter int REGION_BITS = DEF_REGION_BITS,
  parameter int SELW        = clog2_min1(N_SLOTS)
) (
  input  logic [28:0]            i_addr,
  output logic                   o_hit,
  output logic [N_SLOTS-1:0]     o_sel,
  output logic [SELW-1:0]        o_idx,
  output logic [REGION_BITS-3:0] o_ofs
);

  localparam int FW = 31 - REGION_BITS;

  logic [FW-1:0] w_field;
  logic [31:0]   w_field32;

  assign w_field   = i_addr[28:REGION_BITS-2];
  assign w_field32 = 32'(w_field);
  assign o_ofs     = i_addr[REGION_BITS-3:0];
  assign o_idx     = w_field[SELW-1:0];

  // Any nonzero upper index bit pushes the field past N_SLOTS, so a plain compare covers it.
  always_comb begin
    o_hit = (w_field32 < 32'(N_SLOTS));
    o_sel = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      o_sel[i] = o_hit && (w_field32 == 32'(i));
    end
  end

endmodule

// File: rtl/mcpu_soc_mmio_router.sv
// MMIO router: one transaction in flight between the core's uncached port and
// N_SLOTS peripherals, with unmapped/timeout bus errors and a sticky first-error log.
module mcpu_soc_mmio_router
  import mcpu_soc_mmio_router_pkg::*;
#(
  parameter int N_SLOTS        = 8,
  parameter int REGION_BITS    = DEF_REGION_BITS,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    i_clkrst_core_clk,
  input  logic                    i_clkrst_core_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [28:0]             i_req_addr,
  input  logic [31:0]             i_req_wdata,
  input  logic [3:0]              i_req_wren,
  output logic                    o_resp_valid,
  output logic [31:0]             o_resp_rdata,
  output logic                    o_resp_err,
  output logic [N_SLOTS-1:0]      o_slv_sel,
  output logic [REGION_BITS-3:0]  o_slv_addr,
  output logic [31:0]             o_slv_wdata,
  output logic [3:0]              o_slv_wren,
  input  logic [32*N_SLOTS-1:0]   i_slv_rdata,
  input  logic [N_SLOTS-1:0]      i_slv_ack,
  input  logic                    i_err_clr,
  output logic                    o_err_valid,
  output logic                    o_err_kind,
  output logic [28:0]             o_err_addr
);

  localparam int SELW = clog2_min1(N_SLOTS);
  localparam int CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_e r_state, w_state_nxt;

  logic                   w_dec_hit;
  logic [N_SLOTS-1:0]     w_dec_sel;
  logic [SELW-1:0]        w_dec_idx;
  logic [REGION_BITS-3:0] w_dec_ofs;

  logic [N_SLOTS-1:0]     r_sel;
  logic [SELW-1:0]        r_idx;
  logic [REGION_BITS-3:0] r_slv_addr;
  logic [31:0]            r_slv_wdata;
  logic [3:0]             r_slv_wren;
  logic                   r_is_wr;
  logic [28:0]            r_addr;
  logic [CW-1:0]          r_cnt;
  logic                   r_resp_valid;
  logic [31:0]            r_resp_rdata;
  logic                   r_resp_err;
  logic                   r_err_valid;
  logic                   r_err_kind;
  logic [28:0]            r_err_addr;

  logic                   w_ack;
  logic                   w_timeout;
  logic                   w_new_err;
  logic                   w_new_kind;
  logic [28:0]            w_new_addr;
  logic [31:0]            w_slot_rdata [N_SLOTS];

  mcpu_soc_mmio_decode #(
    .N_SLOTS     (N_SLOTS),
    .REGION_BITS (REGION_BITS),
    .SELW        (SELW)
  ) u_decode (
    .i_addr (i_req_addr),
    .o_hit  (w_dec_hit),
    .o_sel  (w_dec_sel),
    .o_idx  (w_dec_idx),
    .o_ofs  (w_dec_ofs)
  );

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_rd
    assign w_slot_rdata[g] = i_slv_rdata[32*g +: 32];
  end

  // Only the selected slot may complete; a timeout loses to an ack in the same cycle.
  assign w_ack     = (r_state == ST_ACCESS) && |(i_slv_ack & r_sel);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == ST_ACCESS) && (r_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_new_err   = 1'b0;
    w_new_kind  = ERR_UNMAPPED;
    w_new_addr  = r_addr;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_state_nxt = w_dec_hit ? ST_ACCESS : ST_RESP;
          w_new_err   = !w_dec_hit;
          w_new_addr  = i_req_addr;
        end
      end
      ST_ACCESS: begin
        if (w_ack || w_timeout) w_state_nxt = ST_RESP;
        w_new_err  = w_timeout && !w_ack;
        w_new_kind = ERR_TIMEOUT;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clkrst_core_clk) begin
    if (!i_clkrst_core_rst_n) r_state <= ST_IDLE;
    else                      r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clkrst_core_clk) begin
    if (!i_clkrst_core_rst_n) begin
      r_sel        <= '0;
      r_idx        <= '0;
      r_slv_addr   <= '0;
      r_slv_wdata  <= '0;
      r_slv_wren   <= '0;
      r_is_wr      <= 1'b0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_addr      <= i_req_addr;
            r_idx       <= w_dec_idx;
            r_slv_addr  <= w_dec_ofs;
            r_slv_wdata <= i_req_wdata;
            r_is_wr     <= |i_req_wren;
            r_cnt       <= '0;
            if (w_dec_hit) begin
              r_sel      <= w_dec_sel;
              r_slv_wren <= i_req_wren;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_ack || w_timeout) begin
            r_sel        <= '0;
            r_slv_wren   <= '0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= !w_ack;
            r_resp_rdata <= (w_ack && !r_is_wr) ? w_slot_rdata[r_idx] : 32'h0;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_cnt        <= '0;
        end
      endcase
    end
  end

  // First error wins; a clear in the same cycle as a new error lets the new one in.
  always_ff @(posedge i_clkrst_core_clk) begin
    if (!i_clkrst_core_rst_n) begin
      r_err_valid <= 1'b0;
      r_err_kind  <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_new_err && (!r_err_valid || i_err_clr)) begin
      r_err_valid <= 1'b1;
      r_err_kind  <= w_new_kind;
      r_err_addr  <= w_new_addr;
    end else if (i_err_clr) begin
      r_err_valid <= 1'b0;
      r_err_kind  <= 1'b0;
      r_err_addr  <= '0;
    end
  end

  assign o_req_ready  = (r_state == ST_IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_slv_sel    = r_sel;
  assign o_slv_addr   = r_slv_addr;
  assign o_slv_wdata  = r_slv_wdata;
  assign o_slv_wren   = r_slv_wren;
  assign o_err_valid  = r_err_valid;
  assign o_err_kind   = r_err_kind;
  assign o_err_addr   = r_err_addr;

endmodule

// File: tb/tb_mcpu_soc_mmio_router.sv
// Scenario bench for the MMIO router: directed and randomized transactions
// against a transaction-level reference model of latency, select time, data and error log.
module tb_mcpu_soc_mmio_router;
  localparam int N  = 8;
  localparam int RB = 12;
  localparam int T  = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready, resp_valid, resp_err, err_clr, err_valid, err_kind;
  logic [28:0] req_addr, err_addr;
  logic [31:0] req_wdata, resp_rdata, slv_wdata;
  logic [3:0]  req_wren, slv_wren;
  logic [N-1:0] slv_sel, slv_ack;
  logic [RB-3:0] slv_addr;
  logic [32*N-1:0] slv_rdata;
  logic [31:0] slot_data [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_sd
    assign slv_rdata[32*g +: 32] = slot_data[g];
  end

  mcpu_soc_mmio_router #(.N_SLOTS(N), .REGION_BITS(RB), .TIMEOUT_CYCLES(T)) dut (
    .i_clkrst_core_clk(clk), .i_clkrst_core_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_wren(req_wren),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_slv_sel(slv_sel), .o_slv_addr(slv_addr), .o_slv_wdata(slv_wdata), .o_slv_wren(slv_wren),
    .i_slv_rdata(slv_rdata), .i_slv_ack(slv_ack), .i_err_clr(err_clr),
    .o_err_valid(err_valid), .o_err_kind(err_kind), .o_err_addr(err_addr)
  );

  // Reference model: transaction-level outcome and sticky error log
  typedef struct { int lat; int selcnt; logic [31:0] rdata; logic err; } exp_t;
  logic        m_ev;
  logic        m_ek;
  logic [28:0] m_ea;

  function automatic exp_t model(input logic [28:0] a, input logic [3:0] wr, input int dly);
    exp_t e;
    int slot = int'(a[28:10]);
    if (slot >= N) begin
      e.lat = 1; e.selcnt = 0; e.err = 1'b1;
    end else if (dly < T) begin
      e.lat = dly + 2; e.selcnt = dly + 1; e.err = 1'b0;
    end else begin
      e.lat = T + 1; e.selcnt = T; e.err = 1'b1;
    end
    e.rdata = (e.err || wr != 4'b0) ? 32'h0 : slot_data[slot];
    return e;
  endfunction

  task automatic model_log(input logic [28:0] a, input logic err, input bit clr);
    if (clr) begin m_ev = 1'b0; m_ek = 1'b0; m_ea = '0; end
    if (err && !m_ev) begin
      m_ev = 1'b1;
      m_ek = (int'(a[28:10]) < N);
      m_ea = a;
    end
  endtask

  // Observations of the last transaction
  int          o_lat, o_selcnt;
  logic [31:0] o_rdata;
  logic        o_err;
  bit          o_selbad, o_wrenbad, o_readybad, o_portbad;

  task automatic run_txn(input logic [28:0] a, input logic [31:0] wd, input logic [3:0] wr,
                         input int dly, input bit spur, input bit clr);
    int slot = int'(a[28:10]);
    @(negedge clk);
    o_readybad = !req_ready;
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_wren = wr; err_clr = clr;
    @(negedge clk);
    req_valid = 1'b0; err_clr = 1'b0;
    o_lat = -1; o_selcnt = 0; o_rdata = 'x; o_err = 1'bx;
    o_selbad = 0; o_wrenbad = 0; o_portbad = 0;
    for (int k = 1; k <= 60; k++) begin
      if (resp_valid) begin
        o_lat = k; o_rdata = resp_rdata; o_err = resp_err;
        break;
      end
      if (req_ready) o_readybad = 1;
      if (slv_sel != '0) begin
        if (slot < N && slv_sel == (N'(1) << slot)) o_selcnt++;
        else o_selbad = 1;
        if (slv_wren !== wr) o_wrenbad = 1;
        if (slv_addr !== a[RB-3:0] || slv_wdata !== wd) o_portbad = 1;
      end else if (slv_wren !== 4'b0) o_wrenbad = 1;
      slv_ack = '0;
      if (slot < N && k == dly + 1) slv_ack[slot] = 1'b1;
      if (spur) slv_ack[5] = 1'b1;
      @(negedge clk);
    end
    slv_ack = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, resp_err} !== 3'b100) begin
      n_bad++; $display("FAIL reset_hs: got %b want 100", {req_ready, resp_valid, resp_err});
    end
    n_cmp++;
    if (resp_rdata !== 32'h0 || slv_sel !== '0 || slv_addr !== '0 || slv_wdata !== 32'h0 || slv_wren !== 4'h0) begin
      n_bad++; $display("FAIL reset_bus: rdata=%h sel=%b addr=%h wdata=%h wren=%b want all 0",
                        resp_rdata, slv_sel, slv_addr, slv_wdata, slv_wren);
    end
    n_cmp++;
    if ({err_valid, err_kind, err_addr} !== 31'h0) begin
      n_bad++; $display("FAIL reset_errlog: v=%b k=%b a=%h want 0", err_valid, err_kind, err_addr);
    end
    rst_n = 1'b1;
    m_ev = 1'b0; m_ek = 1'b0; m_ea = '0;
  endtask

  task automatic test_read_slot3;
    logic [28:0] a = {19'd3, 10'h2A};
    slot_data[3] = 32'h1234_5678;
    run_txn(a, 32'hDEAD_BEEF, 4'b0, 0, 0, 0);
    n_cmp++;
    if (o_lat !== 2 || o_rdata !== 32'h1234_5678 || o_err !== 1'b0) begin
      n_bad++; $display("FAIL read_slot3: lat=%0d rdata=%h err=%b want 2 12345678 0", o_lat, o_rdata, o_err);
    end
    n_cmp++;
    if (o_selcnt !== 1 || o_selbad || o_portbad || o_readybad) begin
      n_bad++; $display("FAIL read_slot3_bus: selcnt=%0d selbad=%0d portbad=%0d readybad=%0d want 1 0 0 0",
                        o_selcnt, o_selbad, o_portbad, o_readybad);
    end
  endtask

  task automatic test_write_slot1;
    run_txn({19'd1, 10'h3FF}, 32'hA5A5_0F0F, 4'b0011, 4, 0, 0);
    n_cmp++;
    if (o_selcnt !== 5 || o_wrenbad || o_portbad || o_selbad) begin
      n_bad++; $display("FAIL write_slot1_bus: selcnt=%0d wrenbad=%0d portbad=%0d selbad=%0d want 5 0 0 0",
                        o_selcnt, o_wrenbad, o_portbad, o_selbad);
    end
    n_cmp++;
    if (o_lat !== 6 || o_rdata !== 32'h0 || o_err !== 1'b0) begin
      n_bad++; $display("FAIL write_slot1_resp: lat=%0d rdata=%h err=%b want 6 0 0", o_lat, o_rdata, o_err);
    end
  endtask

  task automatic test_unmapped;
    logic [28:0] a = {19'd8, 10'h011};
    run_txn(a, 32'h0, 4'b0, 0, 0, 0);
    model_log(a, 1'b1, 0);
    n_cmp++;
    if (o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'h0 || o_selcnt !== 0 || o_selbad) begin
      n_bad++; $display("FAIL unmapped_resp: lat=%0d err=%b rdata=%h selcnt=%0d want 1 1 0 0",
                        o_lat, o_err, o_rdata, o_selcnt);
    end
    n_cmp++;
    if (err_valid !== 1'b1 || err_kind !== 1'b0 || err_addr !== a) begin
      n_bad++; $display("FAIL unmapped_log: v=%b k=%b a=%h want 1 0 %h", err_valid, err_kind, err_addr, a);
    end
  endtask

  task automatic test_err_clr;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    model_log('0, 1'b0, 1);
    n_cmp++;
    if (err_valid !== 1'b0) begin
      n_bad++; $display("FAIL err_clr: err_valid=%b want 0", err_valid);
    end
  endtask

  task automatic test_timeout;
    logic [28:0] a1 = {19'd2, 10'h100};
    logic [28:0] a2 = {19'd2, 10'h200};
    run_txn(a1, 32'h0, 4'b0, 1000, 0, 0);
    model_log(a1, 1'b1, 0);
    n_cmp++;
    if (o_selcnt !== T || o_err !== 1'b1 || o_lat !== T + 1 || o_rdata !== 32'h0) begin
      n_bad++; $display("FAIL timeout_resp: selcnt=%0d err=%b lat=%0d rdata=%h want %0d 1 %0d 0",
                        o_selcnt, o_err, o_lat, o_rdata, T, T + 1);
    end
    n_cmp++;
    if (err_valid !== 1'b1 || err_kind !== 1'b1 || err_addr !== a1) begin
      n_bad++; $display("FAIL timeout_log: v=%b k=%b a=%h want 1 1 %h", err_valid, err_kind, err_addr, a1);
    end
    run_txn(a2, 32'h0, 4'b0, 1000, 0, 0);
    model_log(a2, 1'b1, 0);
    n_cmp++;
    if (err_addr !== m_ea || err_kind !== m_ek || o_err !== 1'b1) begin
      n_bad++; $display("FAIL timeout_second_keeps: a=%h k=%b err=%b want %h %b 1", err_addr, err_kind, o_err, m_ea, m_ek);
    end
  endtask

  task automatic test_ack_last_spurious;
    exp_t e;
    slot_data[2] = 32'hCAFE_F00D;
    e = model({19'd2, 10'h004}, 4'b0, T - 1);
    run_txn({19'd2, 10'h004}, 32'h0, 4'b0, T - 1, 1, 0);
    n_cmp++;
    if (o_err !== e.err || o_rdata !== e.rdata || o_selcnt !== e.selcnt || o_lat !== e.lat) begin
      n_bad++; $display("FAIL ack_last: err=%b rdata=%h selcnt=%0d lat=%0d want %b %h %0d %0d",
                        o_err, o_rdata, o_selcnt, o_lat, e.err, e.rdata, e.selcnt, e.lat);
    end
    e = model({19'd2, 10'h008}, 4'b0, 3);
    run_txn({19'd2, 10'h008}, 32'h0, 4'b0, 3, 1, 0);
    n_cmp++;
    if (o_lat !== e.lat || o_selcnt !== e.selcnt || o_rdata !== e.rdata || o_selbad) begin
      n_bad++; $display("FAIL spurious_ack: lat=%0d selcnt=%0d rdata=%h want %0d %0d %h",
                        o_lat, o_selcnt, o_rdata, e.lat, e.selcnt, e.rdata);
    end
  endtask

  task automatic test_clr_with_unmapped;
    logic [28:0] a = {19'h7_0000, 10'h055};
    run_txn(a, 32'h0, 4'b0, 0, 0, 1);
    model_log(a, 1'b1, 1);
    n_cmp++;
    if (err_valid !== 1'b1 || err_kind !== 1'b0 || err_addr !== a || o_err !== 1'b1) begin
      n_bad++; $display("FAIL clr_with_unmapped: v=%b k=%b a=%h err=%b want 1 0 %h 1",
                        err_valid, err_kind, err_addr, o_err, a);
    end
  endtask

  task automatic test_back_to_back;
    int lats [3];
    bit rb = 0;
    slot_data[0] = 32'h1111_0000; slot_data[4] = 32'h4444_0000;
    run_txn({19'd0, 10'h001}, 32'h0, 4'b0, 0, 0, 0); lats[0] = o_lat; rb |= o_readybad;
    run_txn({19'd9, 10'h001}, 32'h0, 4'b0, 0, 0, 0); lats[1] = o_lat; rb |= o_readybad;
    run_txn({19'd4, 10'h001}, 32'h0, 4'b0, 1, 0, 0); lats[2] = o_lat; rb |= o_readybad;
    n_cmp++;
    if (lats[0] !== 2 || lats[1] !== 1 || lats[2] !== 3 || rb || o_rdata !== 32'h4444_0000) begin
      n_bad++; $display("FAIL back_to_back: lat=%0d,%0d,%0d readybad=%0d rdata=%h want 2,1,3 0 44440000",
                        lats[0], lats[1], lats[2], rb, o_rdata);
    end
    model_log({19'd9, 10'h001}, 1'b1, 0);
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = {19'd2, 10'h0}; req_wdata = 32'h0; req_wren = 4'b1111;
    @(negedge clk); req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (slv_sel !== '0 || slv_wren !== 4'h0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || err_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid: sel=%b wren=%b rv=%b rdy=%b ev=%b want 0 0 0 1 0",
                        slv_sel, slv_wren, resp_valid, req_ready, err_valid);
    end
    rst_n = 1'b1;
    m_ev = 1'b0; m_ek = 1'b0; m_ea = '0;
    repeat (T + 4) begin
      @(negedge clk);
      if (resp_valid || slv_sel != '0) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL reset_mid_quiet: activity=1 want 0");
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [28:0] a;
      logic [3:0]  wr;
      int dly, idx;
      bit spur, clr;
      exp_t e;
      idx = int'($urandom_range(0, 9));
      if ($urandom % 8 == 0) idx = int'($urandom_range(9, 524287));
      a   = {idx[18:0], 10'($urandom)};
      wr  = ($urandom % 2 == 0) ? 4'b0 : 4'($urandom);
      dly = ($urandom % 6 == 0) ? 1000 : int'($urandom_range(0, 20));
      spur = (idx != 5) && ($urandom % 3 == 0);
      clr  = ($urandom % 5 == 0);
      for (int s = 0; s < N; s++) slot_data[s] = $urandom;
      e = model(a, wr, dly);
      run_txn(a, $urandom, wr, dly, spur, clr);
      model_log(a, e.err, clr);
      n_cmp++;
      if (o_lat !== e.lat || o_selcnt !== e.selcnt || o_rdata !== e.rdata || o_err !== e.err) begin
        n_bad++; $display("FAIL rand_resp[%0d]: lat=%0d sel=%0d rdata=%h err=%b want %0d %0d %h %b",
                          n, o_lat, o_selcnt, o_rdata, o_err, e.lat, e.selcnt, e.rdata, e.err);
      end
      n_cmp++;
      if (o_selbad || o_wrenbad || o_portbad || o_readybad) begin
        n_bad++; $display("FAIL rand_bus[%0d]: selbad=%0d wrenbad=%0d portbad=%0d readybad=%0d want 0",
                          n, o_selbad, o_wrenbad, o_portbad, o_readybad);
      end
      n_cmp++;
      if (err_valid !== m_ev || (m_ev && (err_kind !== m_ek || err_addr !== m_ea))) begin
        n_bad++; $display("FAIL rand_log[%0d]: v=%b k=%b a=%h want %b %b %h",
                          n, err_valid, err_kind, err_addr, m_ev, m_ek, m_ea);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_wren = '0;
    slv_ack = '0; err_clr = 1'b0;
    for (int s = 0; s < N; s++) slot_data[s] = 32'h0;
    test_reset;
    test_read_slot3;
    test_write_slot1;
    test_unmapped;
    test_err_clr;
    test_timeout;
    test_ack_last_spurious;
    test_clr_with_unmapped;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
